fetch_unit: RTL and testbench

Instruction fetch stage sitting directly upstream of `mem_access`. It owns the program counter, loads it from the reset vector after reset, and issues sequential byte reads through `mem_access` (PC-sourced address, read only). It assembles each opcode with its 0–2 operand bytes into one instruction word for the decode/execute stage. It holds that word under a valid/ack handshake and accepts PC redirects from execute.

---
 rtl/mos_pkg.sv | 36 +++
 rtl/fetch_unit_if.sv | 33 +++
 rtl/fetch_unit_ins_len_dec.sv | 14 +
 rtl/fetch_unit.sv | 153 +++++++++++++++
 tb/tb_fetch_unit.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/mos_pkg.sv
// Shared definitions for the fetch/decode path: fetch FSM states,
// the default reset-vector address and the instruction length rule.
package mos_pkg;

    localparam logic [15:0] RESET_VEC_DEFAULT = 16'hFFFC;

    typedef enum logic [2:0] {
        ST_VEC_LO = 3'd0,
        ST_VEC_HI = 3'd1,
        ST_OP     = 3'd2,
        ST_OPR_LO = 3'd3,
        ST_OPR_HI = 3'd4,
        ST_HOLD   = 3'd5
    } fetch_state_e;

    // Total instruction length in bytes (opcode plus operands), 1..3.
    // The checks are ordered: earlier rules override later ones.
    function automatic logic [1:0] ins_length(input logic [7:0] op);
        logic [1:0] len;
        if (op == 8'h20) begin
            len = 2'd3;
        end else if ((op == 8'h00) || (op == 8'h40) || (op == 8'h60)) begin
            len = 2'd1;
        end else if ((op[3:0] == 4'h8) || (op[3:0] == 4'hA)) begin
            len = 2'd1;
        end else if (op[3:2] == 2'b11) begin
            len = 2'd3;
        end else if (op[4:0] == 5'b11001) begin
            len = 2'd3;
        end else begin
            len = 2'd2;
        end
        return len;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Bundle of the fetch stage's memory-side and instruction-side signals.
// master = the fetch unit, slave = its environment (memory + execute).
interface fetch_unit_if;

    logic        jump;
    logic [15:0] jump_addr;
    logic        ins_ack;
    logic [7:0]  mem_data;

    logic        mem_en;
    logic        mem_pc_data;
    logic        mem_w_rd;
    logic [15:0] mem_pc;
    logic [7:0]  opcode;
    logic [15:0] operand;
    logic [1:0]  ins_len;
    logic [15:0] ins_pc;
    logic        ins_valid;
    logic        busy;

    modport master (
        input  jump, jump_addr, ins_ack, mem_data,
        output mem_en, mem_pc_data, mem_w_rd, mem_pc,
               opcode, operand, ins_len, ins_pc, ins_valid, busy
    );

    modport slave (
        output jump, jump_addr, ins_ack, mem_data,
        input  mem_en, mem_pc_data, mem_w_rd, mem_pc,
               opcode, operand, ins_len, ins_pc, ins_valid, busy
    );

endinterface

// File: rtl/fetch_unit_ins_len_dec.sv
// Combinational opcode length decoder, shared rule from mos_pkg.
module ins_len_dec
    import mos_pkg::*;
(
    input  logic [7:0] i_opcode,
    output logic [1:0] o_len
);

    // Decode the byte currently on the memory data bus
    always_comb begin
        o_len = ins_length(i_opcode);
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: loads the PC from the reset vector, reads one
// byte per cycle, assembles opcode + operands and holds the result for
// the execute stage under a valid/ack handshake. Execute may redirect.
module fetch_unit
    import mos_pkg::*;
#(
    parameter logic [15:0] RESET_VEC = RESET_VEC_DEFAULT
)
(
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);

    fetch_state_e r_state;
    fetch_state_e w_nextState;

    logic [15:0] r_pc;
    logic [7:0]  r_vecLo;
    logic [7:0]  r_curOp;
    logic [1:0]  r_curLen;
    logic [15:0] r_curPc;
    logic [7:0]  r_curLo;

    logic [7:0]  r_opcode;
    logic [15:0] r_operand;
    logic [1:0]  r_insLen;
    logic [15:0] r_insPc;
    logic        r_insValid;

    logic [1:0]  w_decLen;
    logic        w_jumpTaken;
    logic        w_enterHold;

    ins_len_dec u_lenDec (
        .i_opcode (bus.mem_data),
        .o_len    (w_decLen)
    );

    // Redirects are honoured everywhere except during the vector reads
    always_comb begin
        w_jumpTaken = bus.jump && (r_state != ST_VEC_LO) && (r_state != ST_VEC_HI);
        w_enterHold = (r_state != ST_HOLD) && (w_nextState == ST_HOLD);
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_VEC_LO;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic; a redirect overrides the normal sequence
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_VEC_LO: w_nextState = ST_VEC_HI;
            ST_VEC_HI: w_nextState = ST_OP;
            ST_OP:     w_nextState = (w_decLen == 2'd1) ? ST_HOLD : ST_OPR_LO;
            ST_OPR_LO: w_nextState = (r_curLen == 2'd2) ? ST_HOLD : ST_OPR_HI;
            ST_OPR_HI: w_nextState = ST_HOLD;
            ST_HOLD:   w_nextState = bus.ins_ack ? ST_OP : ST_HOLD;
            default:   w_nextState = ST_VEC_LO;
        endcase
        if (w_jumpTaken) begin
            w_nextState = ST_OP;
        end
    end

    // PC and partial-instruction staging registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc     <= RESET_VEC;
            r_vecLo  <= 8'h00;
            r_curOp  <= 8'h00;
            r_curLen <= 2'd0;
            r_curPc  <= 16'h0000;
            r_curLo  <= 8'h00;
        end else if (w_jumpTaken) begin
            r_pc <= bus.jump_addr;
        end else begin
            case (r_state)
                ST_VEC_LO: begin
                    r_vecLo <= bus.mem_data;
                    r_pc    <= r_pc + 16'd1;
                end
                ST_VEC_HI: begin
                    r_pc <= {bus.mem_data, r_vecLo};
                end
                ST_OP: begin
                    r_curOp  <= bus.mem_data;
                    r_curLen <= w_decLen;
                    r_curPc  <= r_pc;
                    r_pc     <= r_pc + 16'd1;
                end
                ST_OPR_LO: begin
                    r_curLo <= bus.mem_data;
                    r_pc    <= r_pc + 16'd1;
                end
                ST_OPR_HI: begin
                    r_pc <= r_pc + 16'd1;
                end
                default: begin
                    r_pc <= r_pc;
                end
            endcase
        end
    end

    // Held instruction: only updated when a complete instruction enters HOLD
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_opcode   <= 8'h00;
            r_operand  <= 16'h0000;
            r_insLen   <= 2'd0;
            r_insPc    <= 16'h0000;
            r_insValid <= 1'b0;
        end else begin
            r_insValid <= (w_nextState == ST_HOLD);
            if (w_enterHold) begin
                if (r_state == ST_OP) begin
                    r_opcode  <= bus.mem_data;
                    r_operand <= 16'h0000;
                    r_insLen  <= 2'd1;
                    r_insPc   <= r_pc;
                end else begin
                    r_opcode  <= r_curOp;
                    r_insLen  <= r_curLen;
                    r_insPc   <= r_curPc;
                    r_operand <= (r_state == ST_OPR_HI) ? {bus.mem_data, r_curLo}
                                                        : {8'h00, bus.mem_data};
                end
            end
        end
    end

    // Memory request and status outputs, forced quiet while in reset
    always_comb begin
        bus.mem_en      = rst && (r_state != ST_HOLD);
        bus.busy        = rst && (r_state != ST_HOLD);
        bus.mem_pc      = rst ? r_pc : 16'h0000;
        bus.mem_pc_data = 1'b1;
        bus.mem_w_rd    = 1'b1;
        bus.opcode      = r_opcode;
        bus.operand     = r_operand;
        bus.ins_len     = r_insLen;
        bus.ins_pc      = r_insPc;
        bus.ins_valid   = r_insValid;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: byte-array memory, directed scenarios and a
// randomized instruction/jump stream checked against a simple model.
module tb_fetch_unit;

    logic clk;
    logic rst;

    fetch_unit_if bus ();

    fetch_unit #(.RESET_VEC(16'hFFFC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0] mem [0:65535];

    int checkCount = 0;
    int errCount   = 0;

    logic [15:0] pc;
    logic [15:0] tgt;
    int          len;
    int          jCyc;
    int          dly;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory returns the addressed byte in the same cycle
    assign bus.mem_data = mem[bus.mem_pc];

    // Instruction length from the opcode rules, written arithmetically
    function automatic int refLen(input logic [7:0] op);
        int v;
        v = int'(op);
        if (v == 32) return 3;
        if (v == 0 || v == 64 || v == 96) return 1;
        if ((v % 16) == 8 || (v % 16) == 10) return 1;
        if (((v / 4) % 4) == 3) return 3;
        if ((v % 32) == 25) return 3;
        return 2;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive execute-side controls for one cycle, then release them
    task automatic applyStimulus(input logic jmp, input logic [15:0] addr, input logic ack);
        bus.jump      = jmp;
        bus.jump_addr = addr;
        bus.ins_ack   = ack;
        @(negedge clk);
        bus.jump      = 1'b0;
        bus.ins_ack   = 1'b0;
    endtask

    // Starting in the opcode cycle at p, follow the byte reads and check
    // the instruction that lands in the holding registers
    task automatic expectInstr(input logic [15:0] p, input string tag, output int lenOut);
        logic [7:0]  op;
        logic [15:0] opr;
        op     = mem[p];
        lenOut = refLen(op);
        if (lenOut == 3)      opr = {mem[p + 16'd2], mem[p + 16'd1]};
        else if (lenOut == 2) opr = {8'h00, mem[p + 16'd1]};
        else                  opr = 16'h0000;
        for (int k = 0; k < lenOut; k++) begin
            checkOutput({tag, "_addr"}, {15'd0, bus.mem_en, bus.mem_pc}, {15'd0, 1'b1, 16'(int'(p) + k)});
            checkOutput({tag, "_nvalid"}, {31'd0, bus.ins_valid}, 32'd0);
            @(negedge clk);
        end
        checkOutput({tag, "_valid"}, {31'd0, bus.ins_valid}, 32'd1);
        checkOutput({tag, "_opcode"}, {24'd0, bus.opcode}, {24'd0, op});
        checkOutput({tag, "_operand"}, {16'd0, bus.operand}, {16'd0, opr});
        checkOutput({tag, "_len"}, {30'd0, bus.ins_len}, 32'(lenOut));
        checkOutput({tag, "_inspc"}, {16'd0, bus.ins_pc}, {16'd0, p});
        checkOutput({tag, "_holdidle"}, {30'd0, bus.mem_en, bus.busy}, 32'd0);
    endtask

    initial begin
        rst           = 1'b0;
        bus.jump      = 1'b0;
        bus.jump_addr = 16'h0000;
        bus.ins_ack   = 1'b0;
        for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);

        mem[16'hFFFC] = 8'h34; mem[16'hFFFD] = 8'h12;
        mem[16'h1234] = 8'hA9; mem[16'h1235] = 8'h42;
        mem[16'h1236] = 8'h4C; mem[16'h1237] = 8'h00; mem[16'h1238] = 8'h80;
        mem[16'h1239] = 8'hEA;
        mem[16'h123A] = 8'hB9;
        mem[16'h123D] = 8'hD0;
        mem[16'h123F] = 8'h20;
        mem[16'hC000] = 8'h60;

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("rst_outs", {13'd0, bus.mem_en, bus.ins_valid, bus.busy, bus.mem_pc},
                    32'd0);
        checkOutput("rst_const", {30'd0, bus.mem_pc_data, bus.mem_w_rd}, 32'd3);
        checkOutput("rst_held", {bus.opcode, bus.operand, 6'd0, bus.ins_len}, 32'd0);

        // Vector fetch
        rst = 1'b1;
        #1;
        checkOutput("vec_lo", {15'd0, bus.mem_en, bus.mem_pc}, {15'd0, 17'h1FFFC});
        @(negedge clk);
        checkOutput("vec_hi", {15'd0, bus.mem_en, bus.mem_pc}, {15'd0, 17'h1FFFD});
        @(negedge clk);

        // Two-byte immediate, then a wait without ack
        expectInstr(16'h1234, "imm", len);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput("imm_stall", {15'd0, bus.ins_valid, bus.mem_en, bus.opcode, bus.operand[7:0]},
                        {15'd0, 1'b1, 1'b0, 8'hA9, 8'h42});
        end
        applyStimulus(1'b0, 16'h0000, 1'b1);
        checkOutput("ack_refetch", {14'd0, bus.ins_valid, bus.mem_en, bus.mem_pc}, {14'd0, 2'b01, 16'h1236});

        expectInstr(16'h1236, "abs", len);
        checkOutput("abs_fixed", {14'd0, bus.ins_len, bus.operand}, {14'd0, 2'd3, 16'h8000});
        applyStimulus(1'b0, 16'h0000, 1'b1);
        expectInstr(16'h1239, "nop", len);
        checkOutput("nop_fixed", {14'd0, bus.ins_len, bus.operand}, {14'd0, 2'd1, 16'h0000});
        applyStimulus(1'b0, 16'h0000, 1'b1);
        expectInstr(16'h123A, "absy", len);
        checkOutput("len_B9", {30'd0, bus.ins_len}, 32'd3);
        applyStimulus(1'b0, 16'h0000, 1'b1);
        expectInstr(16'h123D, "bne", len);
        checkOutput("len_D0", {30'd0, bus.ins_len}, 32'd2);
        applyStimulus(1'b0, 16'h0000, 1'b1);

        // Jump during operand-low fetch of a three-byte instruction
        checkOutput("jsr_op", {15'd0, bus.mem_en, bus.mem_pc}, {15'd0, 17'h1123F});
        @(negedge clk);
        applyStimulus(1'b1, 16'hC000, 1'b0);
        checkOutput("abort_addr", {14'd0, bus.ins_valid, bus.mem_en, bus.mem_pc}, {14'd0, 2'b01, 16'hC000});
        expectInstr(16'hC000, "rts", len);

        // Jump and ack together in HOLD: jump wins
        applyStimulus(1'b1, 16'h5000, 1'b1);
        checkOutput("jump_wins", {14'd0, bus.ins_valid, bus.mem_en, bus.mem_pc}, {14'd0, 2'b01, 16'h5000});
        pc = 16'h5000;

        // Randomized stream with acks, delays and aborting jumps
        for (int n = 0; n < 60; n++) begin
            len = refLen(mem[pc]);
            if ($urandom_range(0, 3) == 0) begin
                jCyc = int'($urandom_range(0, len - 1));
                for (int k = 0; k < jCyc; k++) begin
                    checkOutput("rnd_partial", {15'd0, bus.mem_en, bus.mem_pc}, {15'd0, 1'b1, 16'(int'(pc) + k)});
                    @(negedge clk);
                end
                tgt = 16'($urandom);
                applyStimulus(1'b1, tgt, 1'($urandom_range(0, 1)));
                checkOutput("rnd_abort", {14'd0, bus.ins_valid, bus.mem_en, bus.mem_pc}, {14'd0, 2'b01, tgt});
                pc = tgt;
            end else begin
                expectInstr(pc, "rnd", len);
                dly = int'($urandom_range(0, 3));
                for (int c = 0; c < dly; c++) begin
                    @(negedge clk);
                    checkOutput("rnd_hold", {30'd0, bus.ins_valid, bus.mem_en}, 32'd2);
                end
                if ($urandom_range(0, 4) == 0) begin
                    tgt = 16'($urandom);
                    applyStimulus(1'b1, tgt, 1'($urandom_range(0, 1)));
                    pc = tgt;
                end else begin
                    applyStimulus(1'b0, 16'h0000, 1'b1);
                    pc = 16'(int'(pc) + len);
                end
                checkOutput("rnd_next", {14'd0, bus.ins_valid, bus.mem_en, bus.mem_pc}, {14'd0, 2'b01, pc});
            end
        end

        // Asynchronous reset in the operand-high cycle
        mem[16'h3000] = 8'h20; mem[16'h3001] = 8'h11; mem[16'h3002] = 8'h22;
        applyStimulus(1'b1, 16'h3000, 1'b0);
        checkOutput("mid_op", {15'd0, bus.mem_en, bus.mem_pc}, {15'd0, 17'h13000});
        @(negedge clk);
        @(negedge clk);
        checkOutput("mid_oprhi", {15'd0, bus.mem_en, bus.mem_pc}, {15'd0, 17'h13002});
        rst = 1'b0;
        #1;
        checkOutput("mid_rst", {29'd0, bus.ins_valid, bus.mem_en, bus.busy}, 32'd0);

        // Restart through a vector that leads to a wrapping instruction
        mem[16'hFFFC] = 8'hFE; mem[16'hFFFD] = 8'hFF;
        mem[16'hFFFE] = 8'hAD; mem[16'hFFFF] = 8'h10;
        mem[16'h0000] = 8'h20; mem[16'h0001] = 8'hEA;
        @(negedge clk);
        checkOutput("rst_hold_idle", {31'd0, bus.mem_en}, 32'd0);
        rst = 1'b1;
        #1;
        checkOutput("restart_lo", {15'd0, bus.mem_en, bus.mem_pc}, {15'd0, 17'h1FFFC});
        @(negedge clk);
        checkOutput("restart_hi", {15'd0, bus.mem_en, bus.mem_pc}, {15'd0, 17'h1FFFD});
        @(negedge clk);
        expectInstr(16'hFFFE, "wrap", len);
        checkOutput("wrap_operand", {16'd0, bus.operand}, 32'h0000_2010);
        applyStimulus(1'b0, 16'h0000, 1'b1);
        checkOutput("wrap_next", {15'd0, bus.mem_en, bus.mem_pc}, {15'd0, 17'h10001});
        expectInstr(16'h0001, "post_wrap", len);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
